// File: rtl/store_merge.sv
// Narrows byte/halfword/word stores into a word-wide memory without byte enables,
// using read-modify-write for sub-word stores.
module store_merge (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_data,
    input  logic [1:0]  i_req_size,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_re,
    input  logic [31:0] i_mem_rdata,
    output logic        o_mem_we,
    output logic [31:0] o_mem_wdata,
    output logic        o_done,
    output logic        o_err
);
    typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, ERR} state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    state_t      state_reg, state_next;
    logic [31:0] addr_reg, data_reg, word_reg;
    logic [1:0]  size_reg;
    logic [31:0] merged_word;
    logic        handshake, misaligned;

    assign handshake = i_req_valid && (state_reg == IDLE);

    always_comb begin
        case (i_req_size)
            SIZE_BYTE: misaligned = 1'b0;
            SIZE_HALF: misaligned = i_req_addr[0];
            SIZE_WORD: misaligned = |i_req_addr[1:0];
            default:   misaligned = 1'b1;
        endcase
    end

    // Each byte lane either keeps the read word or takes the store data;
    // a halfword feeds data[15:8] into the odd lane of its pair.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic       hit;
            logic [7:0] src;
            assign hit = (size_reg == SIZE_BYTE) ? (addr_reg[1:0] == LANE)
                                                 : (addr_reg[1] == LANE[1]);
            assign src = ((size_reg == SIZE_HALF) && LANE[0]) ? data_reg[15:8] : data_reg[7:0];
            assign merged_word[8*gi +: 8] = hit ? src : i_mem_rdata[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            data_reg  <= '0;
            size_reg  <= '0;
            word_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (handshake) begin
                addr_reg <= i_req_addr;
                data_reg <= i_req_data;
                size_reg <= i_req_size;
                word_reg <= i_req_data;
            end else if (state_reg == MERGE) begin
                word_reg <= merged_word;
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        o_req_ready = 1'b0;
        o_mem_addr  = '0;
        o_mem_re    = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_wdata = '0;
        o_done      = 1'b0;
        o_err       = 1'b0;
        case (state_reg)
            IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    if (misaligned)                   state_next = ERR;
                    else if (i_req_size == SIZE_WORD) state_next = WRITE;
                    else                              state_next = READ;
                end
            end
            READ: begin
                o_mem_re   = 1'b1;
                o_mem_addr = {addr_reg[31:2], 2'b00};
                state_next = MERGE;
            end
            MERGE: state_next = WRITE;
            WRITE: begin
                o_mem_we    = 1'b1;
                o_mem_addr  = {addr_reg[31:2], 2'b00};
                o_mem_wdata = word_reg;
                o_done      = 1'b1;
                state_next  = IDLE;
            end
            ERR: begin
                o_err      = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_store_merge.sv
// Directed bench for store_merge: a cycle-level expectation queue built from the
// store rules, checked every cycle, plus literal checks of key transactions.
module tb_store_merge;
    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_data;
    logic [1:0]  i_req_size;
    logic [31:0] o_mem_addr;
    logic        o_mem_re;
    logic [31:0] i_mem_rdata;
    logic        o_mem_we;
    logic [31:0] o_mem_wdata;
    logic        o_done;
    logic        o_err;

    store_merge dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_addr(i_req_addr), .i_req_data(i_req_data), .i_req_size(i_req_size),
        .o_mem_addr(o_mem_addr), .o_mem_re(o_mem_re), .i_mem_rdata(i_mem_rdata),
        .o_mem_we(o_mem_we), .o_mem_wdata(o_mem_wdata),
        .o_done(o_done), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        ready, re, we, done, err, merge;
        logic [31:0] addr, wdata;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    logic hs_pred = 1'b0;
    logic [31:0] mem_word = 32'h0;

    int          we_cnt = 0, re_cnt = 0, done_cnt = 0, err_cnt = 0;
    int          last_hs_cyc = 0, last_wr_cyc = 0, last_re_cyc = 0, last_err_cyc = 0;
    logic [31:0] last_wr_addr = 0, last_wr_data = 0, last_re_addr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Store semantics stated directly: replace the addressed little-endian lane(s).
    function automatic logic [31:0] model_merge(input logic [31:0] mem, input logic [31:0] a,
                                                input logic [31:0] d, input logic [1:0] s);
        logic [31:0] w;
        int off;
        w = mem;
        off = int'(a % 4);
        if (s == 2'b00) w[8*off +: 8]  = d[7:0];
        else            w[8*off +: 16] = d[15:0];
        return w;
    endfunction

    task automatic push_request(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        exp_t e;
        logic [31:0] ea;
        ea = a & 32'hFFFF_FFFC;
        e = '{ready: 1'b0, re: 1'b0, we: 1'b0, done: 1'b0, err: 1'b0, merge: 1'b0, addr: 32'h0, wdata: 32'h0};
        if (s == 2'b11 || (a % (32'd1 << s)) != 0) begin
            e.err = 1'b1; exp_q.push_back(e);
        end else if (s == 2'b10) begin
            e.we = 1'b1; e.done = 1'b1; e.addr = ea; e.wdata = d; exp_q.push_back(e);
        end else begin
            e.re = 1'b1; e.addr = ea; exp_q.push_back(e);
            e.re = 1'b0; e.addr = 32'h0; e.merge = 1'b1; exp_q.push_back(e);
            e.merge = 1'b0; e.we = 1'b1; e.done = 1'b1; e.addr = ea;
            e.wdata = model_merge(mem_word, a, d, s); exp_q.push_back(e);
        end
    endtask

    // Per-cycle compare and model advance, away from the active edge.
    always @(negedge i_clk) begin
        exp_t cur;
        cyc++;
        cur = '{ready: 1'b1, re: 1'b0, we: 1'b0, done: 1'b0, err: 1'b0, merge: 1'b0, addr: 32'h0, wdata: 32'h0};
        if (!i_rst_n) exp_q.delete();
        else if (exp_q.size() > 0) cur = exp_q.pop_front();
        chk($sformatf("ctrl@%0d", cyc), {27'd0, o_req_ready, o_mem_re, o_mem_we, o_done, o_err},
            {27'd0, cur.ready, cur.re, cur.we, cur.done, cur.err});
        chk($sformatf("addr@%0d", cyc), o_mem_addr, cur.addr);
        chk($sformatf("wdata@%0d", cyc), o_mem_wdata, cur.wdata);
        if (o_mem_re && o_mem_we) chk($sformatf("re_we_excl@%0d", cyc), 32'd1, 32'd0);
        i_mem_rdata = cur.merge ? mem_word : $urandom;
        if (o_mem_we) begin we_cnt++; last_wr_addr = o_mem_addr; last_wr_data = o_mem_wdata; last_wr_cyc = cyc; end
        if (o_mem_re) begin re_cnt++; last_re_addr = o_mem_addr; last_re_cyc = cyc; end
        if (o_done) done_cnt++;
        if (o_err) begin err_cnt++; last_err_cyc = cyc; end
        hs_pred = i_rst_n && cur.ready && i_req_valid;
        if (hs_pred) begin
            last_hs_cyc = cyc;
            push_request(i_req_addr, i_req_data, i_req_size);
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s, input bit hold);
        int n;
        i_req_valid = 1'b1; i_req_addr = a; i_req_data = d; i_req_size = s;
        n = 0;
        do begin @(posedge i_clk); n++; end while (!hs_pred && n < 30);
        if (!hs_pred) begin
            total++; bad++;
            $display("FAIL send_timeout actual=no_handshake required=handshake addr=%h", a);
        end
        #1;
        if (!hold) begin
            i_req_valid = 1'b0; i_req_addr = $urandom; i_req_data = $urandom; i_req_size = 2'($urandom);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin @(posedge i_clk); n++; end while (exp_q.size() != 0 && n < 30);
        if (exp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL idle_timeout actual=%0d required=0 pending", exp_q.size());
        end
        #1;
    endtask

    task automatic check_store(input string name, input logic [31:0] a, input logic [31:0] d,
                               input logic [1:0] s, input logic [31:0] mem,
                               input logic [31:0] exp_addr, input logic [31:0] exp_data);
        int re0, done0, hs;
        mem_word = mem;
        re0 = re_cnt; done0 = done_cnt;
        send(a, d, s, 1'b0);
        hs = last_hs_cyc;
        wait_idle();
        chk({name, "_wr_addr"}, last_wr_addr, exp_addr);
        chk({name, "_wr_data"}, last_wr_data, exp_data);
        chk({name, "_done_cnt"}, done_cnt - done0, 1);
        if (s == 2'b10) begin
            chk({name, "_no_read"}, re_cnt - re0, 0);
            chk({name, "_latency"}, last_wr_cyc - hs, 1);
        end else begin
            chk({name, "_read_addr"}, last_re_addr, exp_addr);
            chk({name, "_read_cyc"}, last_re_cyc - hs, 1);
            chk({name, "_latency"}, last_wr_cyc - hs, 3);
        end
    endtask

    task automatic check_err(input string name, input logic [31:0] a, input logic [1:0] s);
        int err0, re0, we0;
        err0 = err_cnt; re0 = re_cnt; we0 = we_cnt;
        send(a, 32'h1234_5678, s, 1'b0);
        wait_idle();
        chk({name, "_err_cnt"}, err_cnt - err0, 1);
        chk({name, "_err_cyc"}, last_err_cyc - last_hs_cyc, 1);
        chk({name, "_no_mem"}, (re_cnt - re0) + (we_cnt - we0), 0);
    endtask

    initial begin
        int hs_a, done0, we0;
        i_rst_n = 1'b0; i_req_valid = 1'b0; i_req_addr = 0; i_req_data = 0; i_req_size = 0;
        i_mem_rdata = 0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("reset_ready", {31'd0, o_req_ready}, 32'd1);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;

        check_store("word",   32'h100, 32'hDEADBEEF, 2'b10, 32'h0,        32'h100, 32'hDEADBEEF);
        check_store("byte3",  32'h203, 32'h000000AB, 2'b00, 32'h11223344, 32'h200, 32'hAB223344);
        check_store("half2",  32'h012, 32'hFFFFCAFE, 2'b01, 32'h11223344, 32'h010, 32'hCAFE3344);
        check_store("half0",  32'h014, 32'h5555BEEF, 2'b01, 32'hA5A5A5A5, 32'h014, 32'hA5A5BEEF);
        check_store("byte1",  32'h021, 32'h12345677, 2'b00, 32'h00000000, 32'h020, 32'h00007700);

        check_err("mis_half", 32'h001, 2'b01);
        check_err("mis_word", 32'h006, 2'b10);
        check_err("mis_rsvd", 32'h000, 2'b11);

        // Reset dropped while the byte store sits in MERGE.
        mem_word = 32'hCCCCCCCC;
        done0 = done_cnt; we0 = we_cnt;
        send(32'h300, 32'h00000077, 2'b00, 1'b0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b0;
        @(negedge i_clk);
        chk("midrst_ready", {31'd0, o_req_ready}, 32'd1);
        repeat (2) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        repeat (4) @(posedge i_clk);
        #1;
        chk("midrst_no_write", we_cnt - we0, 0);
        chk("midrst_no_done", done_cnt - done0, 0);

        // Back-to-back with valid held: word then byte.
        mem_word = 32'h99999999;
        done0 = done_cnt;
        send(32'h400, 32'h01020304, 2'b10, 1'b1);
        hs_a = last_hs_cyc;
        send(32'h405, 32'hFFFFFF5A, 2'b00, 1'b0);
        chk("b2b_hs_gap", last_hs_cyc - hs_a, 2);
        wait_idle();
        chk("b2b_done_cnt", done_cnt - done0, 2);
        chk("b2b_wr_addr", last_wr_addr, 32'h404);
        chk("b2b_wr_data", last_wr_data, 32'h99995A99);

        repeat (3) @(posedge i_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
